// File: rtl/dot_product_stream.sv
// Streaming FP32 dot product: per-pair multiply, serial accumulate, one result per vector.
// Optional accumulator bias seed enabled with `define DOT_PRODUCT_BIAS_EN.
module dot_product_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_row,
    input  logic [DATA_WIDTH-1:0] in_col,
    input  logic                  in_last,
    input  logic [2:0]            round_mode,
`ifdef DOT_PRODUCT_BIAS_EN
    input  logic [DATA_WIDTH-1:0] bias,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            exceptions,
    output logic                  len_err
);

    localparam int          CW   = $clog2(VECTOR_SIZE + 1);
    localparam logic [31:0] QNAN = 32'h7fc0_0000;
    localparam logic [2:0]  RM_RTZ = 3'b001;
    localparam logic [2:0]  RM_RDN = 3'b010;
    localparam logic [2:0]  RM_RUP = 3'b011;
    localparam logic [2:0]  RM_RMM = 3'b100;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    // sig: [25] leading one, [24:2] fraction, [1] guard, [0] sticky; e is the biased exponent of sig[25].
    // Result is {NV,DZ,OF,UF,NX, fp32}; tininess is detected before rounding.
    function automatic logic [36:0] round_pack(input logic s, input int e,
                                               input logic [25:0] sig, input logic [2:0] rm);
        logic [25:0] m;
        logic [24:0] r;
        logic [31:0] res;
        logic        inc, tiny, nx, of;
        int          ee, sh;
        m    = sig;
        ee   = e;
        tiny = 1'b0;
        of   = 1'b0;
        if (ee < 1) begin
            tiny = 1'b1;
            sh   = 1 - ee;
            if (sh >= 26) m = {25'd0, |sig};
            else          m = (sig >> sh) | {25'd0, |(sig & ((26'd1 << sh) - 26'd1))};
            ee = 0;
        end
        nx = m[1] | m[0];
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s & nx;
            RM_RUP:  inc = ~s & nx;
            RM_RMM:  inc = m[1];
            default: inc = m[1] & (m[0] | m[2]);
        endcase
        r = {1'b0, m[25:2]} + {24'd0, inc};
        if (ee == 0) begin
            if (r[23]) ee = 1;
        end else if (r[24]) begin
            ee = ee + 1;
            r  = r >> 1;
        end
        if (ee >= 255) begin
            of = 1'b1;
            nx = 1'b1;
            if (rm == RM_RTZ || (rm == RM_RDN && !s) || (rm == RM_RUP && s))
                res = {s, 8'hfe, 23'h7f_ffff};
            else
                res = {s, 8'hff, 23'd0};
        end else begin
            res = {s, ee[7:0], r[22:0]};
        end
        return {2'b00, of, tiny & nx, nx, res};
    endfunction

    function automatic logic [36:0] fp_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
        logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, snan;
        logic [23:0] ma, mb;
        logic [47:0] p, pn;
        int          ea, eb, lp;
        s      = a[31] ^ b[31];
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        snan   = (a_nan && !a[22]) || (b_nan && !b[22]);
        if (a_nan || b_nan)                       return {snan, 4'd0, QNAN};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, 4'd0, QNAN};
        if (a_inf || b_inf)                       return {5'd0, s, 8'hff, 23'd0};
        if (a_zero || b_zero)                     return {5'd0, s, 31'd0};
        ma = {|a[30:23], a[22:0]};
        mb = {|b[30:23], b[22:0]};
        ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        p  = {24'd0, ma} * {24'd0, mb};
        lp = 0;
        for (int i = 0; i < 48; i++) if (p[i]) lp = i;
        pn = p << (47 - lp);
        return round_pack(s, ea + eb + lp - 173, {pn[47:23], |pn[22:0]}, rm);
    endfunction

    function automatic logic [36:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm);
        logic        a_nan, b_nan, a_inf, b_inf, snan;
        logic [31:0] x, y;
        logic [23:0] mx, my;
        logic [51:0] big, sml0, sml, sum, sn;
        int          ex, ey, d, lp;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        snan  = (a_nan && !a[22]) || (b_nan && !b[22]);
        if (a_nan || b_nan)                      return {snan, 4'd0, QNAN};
        if (a_inf && b_inf && (a[31] != b[31]))  return {1'b1, 4'd0, QNAN};
        if (a_inf)                               return {5'd0, a[31], 8'hff, 23'd0};
        if (b_inf)                               return {5'd0, b[31], 8'hff, 23'd0};
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
            return {5'd0, (a[31] & b[31]) | ((a[31] ^ b[31]) & (rm == RM_RDN)), 31'd0};
        // Larger magnitude goes to x so the aligned subtraction never goes negative.
        if (b[30:0] > a[30:0]) begin
            x = b; y = a;
        end else begin
            x = a; y = b;
        end
        mx   = {|x[30:23], x[22:0]};
        my   = {|y[30:23], y[22:0]};
        ex   = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey   = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        d    = ex - ey;
        big  = {2'b00, mx, 26'd0};
        sml0 = {2'b00, my, 26'd0};
        if (d >= 52) sml = {51'd0, |my};
        else         sml = (sml0 >> d) | {51'd0, |(sml0 & ((52'd1 << d) - 52'd1))};
        sum = (x[31] == y[31]) ? big + sml : big - sml;
        if (sum == 52'd0) return {5'd0, rm == RM_RDN, 31'd0};
        lp = 0;
        for (int i = 0; i < 52; i++) if (sum[i]) lp = i;
        sn = sum << (51 - lp);
        return round_pack(x[31], ex + lp - 49, {sn[51:27], |sn[26:0]}, rm);
    endfunction

    state_t         state_reg, state_next;
    logic [31:0]    acc_reg, prod_reg, seed;
    logic           pend_reg;
    logic [4:0]     flags_reg, flags_add, flags_mul;
    logic [CW-1:0]  cnt_reg;
    logic           len_err_reg;
    logic [2:0]     rm_reg, rm_eff;
    logic [36:0]    mul_res, add_res;
    logic           accept, vec_full, vec_end;

`ifdef DOT_PRODUCT_BIAS_EN
    assign seed = bias;
`else
    assign seed = 32'd0;
`endif

    // The first pair is multiplied before round_mode has been latched.
    assign rm_eff   = (state_reg == IDLE) ? round_mode : rm_reg;
    assign mul_res  = fp_mul(in_row, in_col, rm_eff);
    assign add_res  = fp_add(acc_reg, prod_reg, rm_reg);
    assign accept   = in_valid && in_ready;
    assign vec_full = (state_reg == IDLE) ? (VECTOR_SIZE == 1)
                                          : (cnt_reg + CW'(1) == CW'(VECTOR_SIZE));
    assign vec_end  = in_last || vec_full;
    assign flags_add = pend_reg ? add_res[36:32] : 5'd0;
    assign flags_mul = accept   ? mul_res[36:32] : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = vec_end ? DRAIN : ACCUM;
            ACCUM:   if (accept && vec_end) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state_reg == IDLE || state_reg == ACCUM);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= 32'd0;
            prod_reg    <= 32'd0;
            pend_reg    <= 1'b0;
            flags_reg   <= 5'd0;
            cnt_reg     <= '0;
            len_err_reg <= 1'b0;
            rm_reg      <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    rm_reg      <= round_mode;
                    acc_reg     <= seed;
                    prod_reg    <= mul_res[31:0];
                    pend_reg    <= 1'b1;
                    flags_reg   <= mul_res[36:32];
                    cnt_reg     <= CW'(1);
                    len_err_reg <= vec_full && !in_last;
                end
                ACCUM: begin
                    // A product left over from a bubble cycle is folded in exactly once.
                    if (pend_reg) acc_reg <= add_res[31:0];
                    flags_reg <= flags_reg | flags_add | flags_mul;
                    pend_reg  <= accept;
                    if (accept) begin
                        prod_reg    <= mul_res[31:0];
                        cnt_reg     <= cnt_reg + CW'(1);
                        len_err_reg <= vec_full && !in_last;
                    end
                end
                DRAIN: begin
                    if (pend_reg) acc_reg <= add_res[31:0];
                    flags_reg <= flags_reg | flags_add;
                    pend_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_data   = acc_reg;
    assign exceptions = flags_reg;
    assign len_err    = len_err_reg;

endmodule
